// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit holding the architectural HI/LO registers.
// state | meaning
// IDLE  | waiting for issue; MTHI/MTLO complete here in one cycle
// RUN   | one multiply or divide iteration per edge, 32 edges total
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_mul;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_rs_orig;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_work_hi;
    logic [WIDTH-1:0]   r_work_lo;

    logic               w_is_signed;
    logic [WIDTH-1:0]   w_rs_abs;
    logic [WIDTH-1:0]   w_rt_abs;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_rs_abs    = (w_is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_abs    = (w_is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Multiply: work_hi:work_lo is the product register with the multiplier
    // shifting out of the bottom. Divide: work_hi is the partial remainder,
    // work_lo shifts the dividend out and the quotient in.
    assign w_add   = {1'b0, r_work_hi} + {1'b0, (r_work_lo[0] ? r_operand : '0)};
    assign w_trial = {r_work_hi, r_work_lo[WIDTH-1]} - {1'b0, r_operand};

    always_comb begin
        w_next_hi = r_work_hi;
        w_next_lo = r_work_lo;
        if (r_is_mul) begin
            w_next_hi = w_add[WIDTH:1];
            w_next_lo = {w_add[0], r_work_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_next_hi = w_trial[WIDTH-1:0];
            w_next_lo = {r_work_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_next_hi = {r_work_hi[WIDTH-2:0], r_work_lo[WIDTH-1]};
            w_next_lo = {r_work_lo[WIDTH-2:0], 1'b0};
        end
    end

    assign w_prod = {w_next_hi, w_next_lo};

    always_comb begin
        w_res_hi = w_next_hi;
        w_res_lo = w_next_lo;
        if (r_is_mul) begin
            {w_res_hi, w_res_lo} = r_neg_q ? -w_prod : w_prod;
        end else if (r_div0) begin
            w_res_hi = r_rs_orig;
            w_res_lo = '1;
        end else begin
            w_res_lo = r_neg_q ? -w_next_lo : w_next_lo;
            w_res_hi = r_neg_r ? -w_next_hi : w_next_hi;
        end
    end

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_mul  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_rs_orig <= '0;
            r_operand <= '0;
            r_work_hi <= '0;
            r_work_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_state   <= S_RUN;
                                r_cnt     <= '0;
                                r_is_mul  <= ~op[1];
                                r_neg_q   <= w_is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                r_neg_r   <= (op == OP_DIV) && rs_val[WIDTH-1];
                                r_div0    <= op[1] && (rt_val == '0);
                                r_rs_orig <= rs_val;
                                r_work_hi <= '0;
                                r_operand <= op[1] ? w_rt_abs : w_rs_abs;
                                r_work_lo <= op[1] ? w_rs_abs : w_rt_abs;
                            end
                            OP_MTHI: r_hi <= rs_val;
                            OP_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_work_hi <= w_next_hi;
                    r_work_lo <= w_next_lo;
                    r_cnt     <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: hand-computed HI/LO results, busy length,
// done pulse, ignored issues while busy, back-to-back issue and mid-run reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns at the negedge after the issue edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] old_hi, input logic [31:0] old_lo,
                             inout int busy_cyc, output bit seen, output bit hold_bad);
        int guard = 0;
        hold_bad = 1'b0;
        while (!done && guard < 40) begin
            if (busy) busy_cyc++;
            if (busy && (hi !== old_hi || lo !== old_lo)) hold_bad = 1'b1;
            guard++;
            @(negedge clk);
        end
        seen = done;
    endtask

    task automatic check_result(input string name, input int bc, input bit seen, input bit hold_bad,
                                input logic [31:0] eh, input logic [31:0] el);
        vectors++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout got done=%b want 1", name, seen);
        end
        vectors++;
        if (bc !== 32) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want 32", name, bc);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_with_done got busy=%b want 0", name, busy);
        end
        vectors++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s hilo_changed_during_run got 1 want 0", name);
        end
        vectors++;
        if (hi !== eh) begin
            errors++;
            $display("FAIL %s hi got %h want %h", name, hi, eh);
        end
        vectors++;
        if (lo !== el) begin
            errors++;
            $display("FAIL %s lo got %h want %h", name, lo, el);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] h0, l0;
        int bc;
        bit seen, bad;
        h0 = hi;
        l0 = lo;
        bc = 0;
        issue(o, a, b);
        wait_done(h0, l0, bc, seen, bad);
        check_result(name, bc, seen, bad, eh, el);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width got done=%b want 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_mt;
        issue(3'd4, 32'h12345678, 32'hFFFFFFFF);
        vectors++;
        if (hi !== 32'h12345678 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi got hi=%h lo=%h busy=%b done=%b want 12345678 0 0 0", hi, lo, busy, done);
        end
        issue(3'd5, 32'h9ABCDEF0, 32'h0);
        vectors++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b want 12345678 9abcdef0 0 0", hi, lo, busy, done);
        end
        issue(3'd6, 32'hCAFEF00D, 32'h1);
        @(negedge clk);
        vectors++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL nop_op6 got hi=%h lo=%h busy=%b done=%b want 12345678 9abcdef0 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_mul;
        run_op("mult_neg2x3",   3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_neg2x3",  3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA);
        run_op("mult_min_sq",   3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("mult_7xneg3",   3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    endtask

    task automatic test_div;
        run_op("div_neg7_2",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2",    3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_100_7",    3'd3, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_overflow",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_by_zero",  3'd3, 32'h55,       32'h0,        32'h00000055, 32'hFFFFFFFF);
        run_op("div_by_zero",   3'd2, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    endtask

    task automatic test_ignore_busy;
        logic [31:0] h0, l0;
        int bc;
        bit seen, bad;
        h0 = hi;
        l0 = lo;
        bc = 0;
        issue(3'd0, 32'd5, 32'd6);
        for (int i = 0; i < 9; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        start = 1'b1; op = 3'd4; rs_val = 32'hDEADBEEF;
        if (busy) bc++;
        @(negedge clk);
        op = 3'd2; rs_val = 32'd100; rt_val = 32'd0;
        if (busy) bc++;
        @(negedge clk);
        start = 1'b0; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
        vectors++;
        if (hi !== h0) begin
            errors++;
            $display("FAIL ignore_mthi hi got %h want %h", hi, h0);
        end
        wait_done(h0, l0, bc, seen, bad);
        check_result("ignore_busy_mult", bc, seen, bad, 32'h0, 32'd30);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_div_not_started got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h0, l0;
        int bc;
        bit seen, bad;
        h0 = hi;
        l0 = lo;
        bc = 0;
        issue(3'd1, 32'd9, 32'd11);
        wait_done(h0, l0, bc, seen, bad);
        check_result("b2b_multu", bc, seen, bad, 32'h0, 32'd99);
        h0 = hi;
        l0 = lo;
        bc = 0;
        issue(3'd3, 32'd100, 32'd7);
        wait_done(h0, l0, bc, seen, bad);
        check_result("b2b_divu", bc, seen, bad, 32'd2, 32'd14);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        bit saw_done;
        issue(3'd2, 32'hFFFFFF9C, 32'd7);
        repeat (14) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || hi === 32'h0) begin
            errors++;
            $display("FAIL rst_mid_precond got busy=%b hi=%h want busy=1 hi!=0", busy, hi);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_done) begin
            errors++;
            $display("FAIL rst_mid_no_done got activity=1 want 0");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mt();
        test_mul();
        test_div();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
